// File: rtl/cfg_bus_master_pkg.sv
// Shared definitions for the cfg bus master: FSM encodings, response constants,
// default timeout and the cfg address map.
package cfg_bus_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [31:0] RSP_TIMEOUT_DATA       = 32'hDEAD_BEEF;
   localparam int          DEFAULT_TIMEOUT_CYCLES = 1024;

   // Slave base addresses; addresses go out untranslated and slaves subtract these.
   localparam logic [15:0] CFG_BASE_SYSCTRL = 16'h5000;
   localparam logic [15:0] CFG_BASE_TIMER   = 16'h5010;
   localparam logic [15:0] CFG_BASE_GPIO    = 16'h5020;
   localparam logic [15:0] CFG_BASE_UART    = 16'h5030;
   localparam logic [15:0] CFG_BASE_SPARE   = 16'h5040;

endpackage

// File: rtl/cfg_bus_master.sv
// Single-outstanding cfg bus master (IDLE -> BUS -> RESP) with registered outputs.
// Optional ack timeout is enabled by defining CFG_MASTER_TIMEOUT_EN.
module cfg_bus_master
   import cfg_bus_master_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] cfg_addr,
   output logic [DATA_W-1:0] cfg_wdata,
   output logic              cfg_write,
   output logic              cfg_read,
   input  logic [DATA_W-1:0] cfg_rdata,
   input  logic              cfg_ack
);

   state_t state_r;
   logic   ack_s;

   // An ack only counts while a strobe is actually on the bus.
   assign ack_s = cfg_ack && (cfg_write || cfg_read);

`ifdef CFG_MASTER_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tmo_cnt_r;
`else
   assign rsp_timeout = 1'b0;
`endif

   // Transaction FSM; every output is a register written here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         req_ready <= 1'b1;
         cfg_write <= 1'b0;
         cfg_read  <= 1'b0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef CFG_MASTER_TIMEOUT_EN
         rsp_timeout <= 1'b0;
         tmo_cnt_r   <= '0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  state_r   <= ST_BUS;
                  req_ready <= 1'b0;
                  cfg_addr  <= req_addr;
                  cfg_wdata <= req_rw ? '0 : req_wdata;
                  cfg_read  <= req_rw;
                  cfg_write <= ~req_rw;
`ifdef CFG_MASTER_TIMEOUT_EN
                  tmo_cnt_r <= '0;
`endif
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ST_BUS: begin
               // Ack is checked first so it wins over a same-cycle expiry.
               if (ack_s) begin
                  state_r   <= ST_RESP;
                  cfg_write <= 1'b0;
                  cfg_read  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= cfg_read ? cfg_rdata : '0;
`ifdef CFG_MASTER_TIMEOUT_EN
                  rsp_timeout <= 1'b0;
`endif
               end
`ifdef CFG_MASTER_TIMEOUT_EN
               else if (tmo_cnt_r == CNT_LAST) begin
                  state_r     <= ST_RESP;
                  cfg_write   <= 1'b0;
                  cfg_read    <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= DATA_W'(RSP_TIMEOUT_DATA);
                  rsp_timeout <= 1'b1;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_r   <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               req_ready <= 1'b1;
               cfg_write <= 1'b0;
               cfg_read  <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_bus_master.sv
// Directed self-checking bench for cfg_bus_master; timeout scenarios are
// exercised when CFG_MASTER_TIMEOUT_EN is defined, indefinite wait otherwise.
module tb_cfg_bus_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_rw;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [15:0] cfg_addr;
   logic [31:0] cfg_wdata, cfg_rdata;
   logic        cfg_write, cfg_read, cfg_ack;

   int n_checks = 0;
   int n_fails  = 0;
   int cnt;

   always #10 clk = ~clk;

   cfg_bus_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_write(cfg_write), .cfg_read(cfg_read),
      .cfg_rdata(cfg_rdata), .cfg_ack(cfg_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 16'h0000;
      req_wdata = 32'h0; rsp_ready = 1'b0; cfg_rdata = 32'h0; cfg_ack = 1'b0;
      tick(); tick();
      chk("rst_write", {63'd0, cfg_write}, 64'd0);
      chk("rst_read", {63'd0, cfg_read}, 64'd0);
      chk("rst_addr", {48'd0, cfg_addr}, 64'd0);
      chk("rst_wdata", {32'd0, cfg_wdata}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
      rst = 1'b0;
      #1;
      chk("req_ready_after_rst", {63'd0, req_ready}, 64'd1);

      // Stray ack while idle must be ignored.
      cfg_ack = 1'b1;
      tick();
      cfg_ack = 1'b0;
      chk("idle_ack_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("idle_ack_req_ready", {63'd0, req_ready}, 64'd1);

      // Write 0x5008 / 0xA5, ack in third strobe cycle.
      cfg_rdata = 32'hFFFF_FFFF;
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h5008; req_wdata = 32'h0000_00A5;
      tick();
      req_valid = 1'b0; req_addr = 16'h0000; req_wdata = 32'h0;
      chk("wr_req_ready_bus", {63'd0, req_ready}, 64'd0);
      chk("wr_read_low", {63'd0, cfg_read}, 64'd0);
      cnt = 0;
      for (int k = 1; k <= 3; k++) begin
         if (cfg_write) cnt++;
         chk("wr_addr_stable", {48'd0, cfg_addr}, 64'h5008);
         chk("wr_data_stable", {32'd0, cfg_wdata}, 64'h0000_00A5);
         chk("wr_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
         if (k == 3) cfg_ack = 1'b1;
         tick();
      end
      cfg_ack = 1'b0;
      chk("wr_strobe_cycles", 64'(cnt), 64'd3);
      chk("wr_strobe_dropped", {63'd0, cfg_write}, 64'd0);
      chk("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("wr_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
      chk("wr_addr_held", {48'd0, cfg_addr}, 64'h5008);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("wr_done_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("wr_done_req_ready", {63'd0, req_ready}, 64'd1);
      chk("idle_addr_held", {48'd0, cfg_addr}, 64'h5008);

      // Read 0x5010 with ack from the first strobe cycle (minimum latency).
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h5010; req_wdata = 32'h5555_AAAA;
      cfg_rdata = 32'h1234_5678; cfg_ack = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rd_c1_read", {63'd0, cfg_read}, 64'd1);
      chk("rd_c1_write", {63'd0, cfg_write}, 64'd0);
      chk("rd_c1_addr", {48'd0, cfg_addr}, 64'h5010);
      chk("rd_c1_wdata_zero", {32'd0, cfg_wdata}, 64'd0);
      chk("rd_c1_no_rsp", {63'd0, rsp_valid}, 64'd0);
      tick();
      cfg_ack = 1'b0; cfg_rdata = 32'h0;
      chk("rd_c2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("rd_c2_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
      chk("rd_c2_read_low", {63'd0, cfg_read}, 64'd0);

      // Backpressure: rsp_ready low 5 cycles while a second request waits.
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h5020;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         chk("bp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
         chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
         chk("bp_no_strobe", {63'd0, cfg_read}, 64'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_hs_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("bp_hs_req_ready", {63'd0, req_ready}, 64'd1);
      chk("bp_hs_not_accepted", {63'd0, cfg_read}, 64'd0);
      tick();
      req_valid = 1'b0;
      chk("bp_2nd_read", {63'd0, cfg_read}, 64'd1);
      chk("bp_2nd_addr", {48'd0, cfg_addr}, 64'h5020);
      cfg_rdata = 32'hCAFE_0001; cfg_ack = 1'b1;
      tick();
      cfg_ack = 1'b0;
      chk("bp_2nd_rdata", {32'd0, rsp_rdata}, 64'hCAFE_0001);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Reset pulsed in the middle of BUS.
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h5030; req_wdata = 32'h0000_0077;
      tick();
      req_valid = 1'b0;
      chk("mid_write_on", {63'd0, cfg_write}, 64'd1);
      #4 rst = 1'b1;
      #1;
      chk("mid_rst_write", {63'd0, cfg_write}, 64'd0);
      chk("mid_rst_addr", {48'd0, cfg_addr}, 64'd0);
      chk("mid_rst_wdata", {32'd0, cfg_wdata}, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h5034; req_wdata = 32'h0000_0055;
      tick();
      req_valid = 1'b0; cfg_ack = 1'b1;
      chk("post_rst_write", {63'd0, cfg_write}, 64'd1);
      chk("post_rst_wdata", {32'd0, cfg_wdata}, 64'h55);
      tick();
      cfg_ack = 1'b0;
      chk("post_rst_rsp", {63'd0, rsp_valid}, 64'd1);
      chk("post_rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

`ifdef CFG_MASTER_TIMEOUT_EN
      // No ack: expiry after 8 strobe cycles; late ack in cycle 10 is ignored.
      cfg_rdata = 32'h1111_2222;
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h5040;
      tick();
      req_valid = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         if (cfg_read) cnt++;
         if (k == 9) begin
            chk("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("to_flag", {63'd0, rsp_timeout}, 64'd1);
            chk("to_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
         end
         cfg_ack = (k == 10);
         tick();
      end
      cfg_ack = 1'b0;
      chk("to_strobe_cycles", 64'(cnt), 64'd8);
      chk("to_late_ack_valid", {63'd0, rsp_valid}, 64'd1);
      chk("to_late_ack_flag", {63'd0, rsp_timeout}, 64'd1);
      chk("to_late_ack_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Ack in the expiry cycle wins.
      cfg_rdata = 32'hABCD_0123;
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h5044;
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cfg_ack = (k == 8);
         tick();
      end
      cfg_ack = 1'b0;
      chk("tie_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("tie_flag", {63'd0, rsp_timeout}, 64'd0);
      chk("tie_rdata", {32'd0, rsp_rdata}, 64'hABCD_0123);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`else
      // Without timeout the strobe waits indefinitely for the ack.
      cfg_rdata = 32'hABCD_0123;
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h5040;
      tick();
      req_valid = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         if (cfg_read && !rsp_valid) cnt++;
         tick();
      end
      chk("wait_strobe_cycles", 64'(cnt), 64'd12);
      chk("wait_no_timeout", {63'd0, rsp_timeout}, 64'd0);
      cfg_ack = 1'b1;
      tick();
      cfg_ack = 1'b0;
      chk("wait_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("wait_rdata", {32'd0, rsp_rdata}, 64'hABCD_0123);
      chk("wait_flag", {63'd0, rsp_timeout}, 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`endif
      chk("final_req_ready", {63'd0, req_ready}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/cfg_bus_master.md
CFG_BUS_MASTER -- requirements
Module: cfg_bus_master

Interface
REQ-001 Parameter ADDR_W, default 16, cfg bus address width.
REQ-002 Parameter DATA_W, default 32, cfg bus data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, ack wait limit in clk cycles (minimum 2).
REQ-004 clk  input  1  system clock (50 MHz); the block uses only this clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  a request is offered.
REQ-007 req_ready  output  1  the block accepts a request this cycle.
REQ-008 req_rw  input  1  1 = read, 0 = write.
REQ-009 req_addr  input  ADDR_W  system address (e.g. 16'h5008).
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  a response is held.
REQ-012 rsp_ready  input  1  the consumer takes the response.
REQ-013 rsp_rdata  output  DATA_W  read data, or a sentinel value.
REQ-014 rsp_timeout  output  1  the transaction ended by timeout.
REQ-015 cfg_addr  output  ADDR_W  bus address.
REQ-016 cfg_wdata  output  DATA_W  bus write data.
REQ-017 cfg_write  output  1  write strobe (level).
REQ-018 cfg_read  output  1  read strobe (level).
REQ-019 cfg_rdata  input  DATA_W  slave read data.
REQ-020 cfg_ack  input  1  slave completion.

Function
REQ-021 The block SHALL implement the FSM states IDLE, BUS and RESP; all outputs SHALL be registered.
REQ-022 IDLE: req_ready=1; on req_valid the block SHALL latch addr, wdata and rw, then go to BUS.
- Strobes SHALL go high in the cycle after acceptance.
- Only the selected strobe SHALL be asserted.
- cfg_wdata SHALL be 0 for a read.
REQ-023 BUS: strobe, cfg_addr and cfg_wdata SHALL stay stable until cfg_ack=1 is sampled with the strobe high.
- In the next cycle, strobes SHALL drop, rsp_valid SHALL be 1 and the state SHALL be RESP.
REQ-024 On ack for a read, rsp_rdata SHALL capture cfg_rdata from the ack cycle; for a write, rsp_rdata SHALL be 0 and rsp_timeout SHALL be 0.
REQ-025 RESP: outputs SHALL be held until rsp_ready=1, then the FSM SHALL return to IDLE.
- req_ready SHALL be 0 in BUS and RESP; there is no back-to-back overlap.
- A new request SHALL be accepted no earlier than the cycle after the handshake.
REQ-026 Minimum request-to-response latency: acceptance at cycle 0, strobe at cycle 1, ack at cycle 1, rsp_valid at cycle 2.
REQ-027 cfg_ack SHALL be ignored outside BUS or while no strobe is asserted.
REQ-028 cfg_addr SHALL hold its last value while idle; cfg_addr is passed through untranslated, and slaves subtract their own base.

Reset
REQ-029 On rst all of the following SHALL happen immediately, and a transaction interrupted by reset SHALL be discarded with no response:
- state IDLE;
- cfg_write=cfg_read=0;
- cfg_addr=0, cfg_wdata=0;
- rsp_valid=0, rsp_rdata=0, rsp_timeout=0;
- timeout counter=0.
REQ-030 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro CFG_MASTER_TIMEOUT_EN defined:
- A counter SHALL clear on entry to BUS and increment each BUS cycle.
- When the counter reaches TIMEOUT_CYCLES-1 without ack, strobes SHALL drop and rsp_valid=1, rsp_timeout=1, rsp_rdata=32'hDEAD_BEEF.
- If ack and expiry fall in the same cycle, ack SHALL win.
- A late ack after timeout SHALL be ignored.
REQ-032 Macro undefined: no counter SHALL be present, BUS SHALL wait indefinitely, and rsp_timeout SHALL be tied to 0.

Structure
REQ-033 A shared package/include SHALL hold the FSM state encodings, the RSP_TIMEOUT_DATA (32'hDEAD_BEEF) constant and the default TIMEOUT_CYCLES, alongside the existing address map.
REQ-034 The design SHALL be a single module with no sub-module; the timeout counter is inline logic.

Verification
REQ-035 Write 0x5008 with data 0x0000_00A5, slave acks after 3 cycles -> cfg_write high exactly 3 cycles, addr and data stable, rsp_valid one cycle after ack with rsp_rdata=0 and rsp_timeout=0.
REQ-036 Read 0x5010, slave returns 0x1234_5678 with ack in the first strobe cycle -> rsp_valid at cycle 2, rsp_rdata=0x1234_5678.
REQ-037 With the macro defined, TIMEOUT_CYCLES=8 and no ack -> strobe drops after 8 cycles, rsp_timeout=1, rsp_rdata=0xDEAD_BEEF; an ack arriving at cycle 10 changes nothing.
REQ-038 rsp_ready held low 5 cycles with req_valid held high -> response stable, req_ready=0, second request accepted only after the handshake.
REQ-039 rst pulsed mid-BUS -> strobes low in the same cycle, no rsp_valid, next request completes normally.
REQ-040 Ack and timeout expiry in the same cycle -> rsp_timeout=0 and rsp_rdata = slave data.
